// File: rtl/hazard_stall_if.sv
// Signal bundle between the D-stage issue logic and the hazard/stall unit.
interface hazard_stall_if;
    logic [31:0] instr_D;
    logic        stall;
    logic        md_busy;
    logic [4:0]  dst_E;
    logic [1:0]  tnew_E;
    logic [4:0]  dst_M;
    logic [1:0]  tnew_M;

    // Pipeline side: presents the D instruction and consumes the stall decision.
    modport master (
        output instr_D,
        input  stall, md_busy, dst_E, tnew_E, dst_M, tnew_M
    );

    // Hazard unit side.
    modport slave (
        input  instr_D,
        output stall, md_busy, dst_E, tnew_E, dst_M, tnew_M
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard and stall controller for a 5-stage MIPS pipeline. Decodes the D-stage
// instruction into operand use times and result production time, keeps a
// shadow of the E and M stages, and stalls D when an operand cannot be
// forwarded in time or when the multiply/divide unit is still busy.
module hazard_stall_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    hazard_stall_if.slave  hz
);

    // Use time 3 means the operand is not read, so no Tnew (max 2) exceeds it.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [5:0] op, fn;
    logic [4:0] rs_D, rt_D, rd_D;

    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] dst_dec;
    logic [1:0] tnew_raw, tnew_dec;
    logic       md_dec, start_dec, div_dec;

    logic [4:0]       dst_e_q, dst_e_d, dst_m_q, dst_m_d;
    logic [1:0]       tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
    logic             start_e_q, start_e_d, div_e_q, div_e_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic data_stall, md_stall, stall;

    assign op   = hz.instr_D[31:26];
    assign rs_D = hz.instr_D[25:21];
    assign rt_D = hz.instr_D[20:16];
    assign rd_D = hz.instr_D[15:11];
    assign fn   = hz.instr_D[5:0];

    // Decode D into use times, destination, Tnew and mult/div class.
    always_comb begin
        tuse_rs   = TUSE_NONE;
        tuse_rt   = TUSE_NONE;
        dst_dec   = 5'd0;
        tnew_raw  = 2'd0;
        md_dec    = 1'b0;
        start_dec = 1'b0;
        div_dec   = 1'b0;
        if (hz.instr_D != 32'd0) begin
            case (op)
                6'h00: begin
                    case (fn)
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                        6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07: begin
                            tuse_rs  = 2'd1;
                            tuse_rt  = 2'd1;
                            dst_dec  = rd_D;
                            tnew_raw = 2'd1;
                        end
                        6'h00, 6'h02, 6'h03: begin
                            tuse_rt  = 2'd1;
                            dst_dec  = rd_D;
                            tnew_raw = 2'd1;
                        end
                        6'h08: tuse_rs = 2'd0;
                        6'h09: begin
                            tuse_rs  = 2'd0;
                            dst_dec  = rd_D;
                            tnew_raw = 2'd0;
                        end
                        6'h18, 6'h19: begin
                            tuse_rs   = 2'd1;
                            tuse_rt   = 2'd1;
                            md_dec    = 1'b1;
                            start_dec = 1'b1;
                        end
                        6'h1A, 6'h1B: begin
                            tuse_rs   = 2'd1;
                            tuse_rt   = 2'd1;
                            md_dec    = 1'b1;
                            start_dec = 1'b1;
                            div_dec   = 1'b1;
                        end
                        6'h11, 6'h13: begin
                            tuse_rs = 2'd1;
                            md_dec  = 1'b1;
                        end
                        6'h10, 6'h12: begin
                            dst_dec  = rd_D;
                            tnew_raw = 2'd1;
                            md_dec   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                6'h01: begin
                    if (rt_D == 5'd0 || rt_D == 5'd1) tuse_rs = 2'd0;
                end
                6'h03: begin
                    dst_dec  = 5'd31;
                    tnew_raw = 2'd0;
                end
                6'h04, 6'h05: begin
                    tuse_rs = 2'd0;
                    tuse_rt = 2'd0;
                end
                6'h06, 6'h07: tuse_rs = 2'd0;
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                    tuse_rs  = 2'd1;
                    dst_dec  = rt_D;
                    tnew_raw = 2'd1;
                end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    tuse_rs  = 2'd1;
                    dst_dec  = rt_D;
                    tnew_raw = 2'd2;
                end
                6'h28, 6'h29, 6'h2B: begin
                    tuse_rs = 2'd1;
                    tuse_rt = 2'd2;
                end
                default: ;
            endcase
        end
    end

    // A write to $0 produces nothing forwardable, so it is tracked like a bubble.
    assign tnew_dec = (dst_dec == 5'd0) ? 2'd0 : tnew_raw;

    // Stall when a producer in E or M will not have its result ready by the use time.
    always_comb begin
        data_stall = 1'b0;
        if (rs_D != 5'd0) begin
            if (rs_D == dst_e_q && tnew_e_q > tuse_rs) data_stall = 1'b1;
            if (rs_D == dst_m_q && tnew_m_q > tuse_rs) data_stall = 1'b1;
        end
        if (rt_D != 5'd0) begin
            if (rt_D == dst_e_q && tnew_e_q > tuse_rt) data_stall = 1'b1;
            if (rt_D == dst_m_q && tnew_m_q > tuse_rt) data_stall = 1'b1;
        end
    end

    assign md_stall = md_dec && ((cnt_q != '0) || start_e_q);
    assign stall    = data_stall || md_stall;

    // Next E/M shadow and busy counter.
    always_comb begin
        if (stall) begin
            dst_e_d   = 5'd0;
            tnew_e_d  = 2'd0;
            start_e_d = 1'b0;
            div_e_d   = 1'b0;
        end else begin
            dst_e_d   = dst_dec;
            tnew_e_d  = tnew_dec;
            start_e_d = start_dec;
            div_e_d   = div_dec;
        end
        dst_m_d  = dst_e_q;
        tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
        cnt_d    = cnt_q;
        if (start_e_q)
            cnt_d = div_e_q ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            dst_e_q   <= 5'd0;
            tnew_e_q  <= 2'd0;
            start_e_q <= 1'b0;
            div_e_q   <= 1'b0;
            dst_m_q   <= 5'd0;
            tnew_m_q  <= 2'd0;
            cnt_q     <= '0;
        end else begin
            dst_e_q   <= dst_e_d;
            tnew_e_q  <= tnew_e_d;
            start_e_q <= start_e_d;
            div_e_q   <= div_e_d;
            dst_m_q   <= dst_m_d;
            tnew_m_q  <= tnew_m_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hz.stall   = stall;
    assign hz.md_busy = (cnt_q != '0);
    assign hz.dst_E   = dst_e_q;
    assign hz.tnew_E  = tnew_e_q;
    assign hz.dst_M   = dst_m_q;
    assign hz.tnew_M  = tnew_m_q;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Sequential hazard and stall controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Decodes the instruction in D into Tuse(rs), Tuse(rt) and destination/Tnew values, and tracks its own shadow of the E and M stages.
- Issues a stall when a D-stage operand cannot be forwarded in time, or when the multiply/divide unit is busy.
- Generalises the flat instruction classifier by adding per-instruction timing, pipeline tracking and parametrised mult/div latencies.

Parameters:
- MULT_LAT, default 5: busy cycles after MULT/MULTU leaves E.
- DIV_LAT, default 10: busy cycles after DIV/DIVU leaves E.
- CNT_W, default 4: busy counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_D  in  32  instruction currently in D.
- stall  out  1  freeze PC and D register; insert bubble into E.
- md_busy  out  1  multiply/divide counter non-zero.
- dst_E  out  5  tracked E destination register (0 = none).
- tnew_E  out  2  tracked E Tnew.
- dst_M  out  5  tracked M destination register.
- tnew_M  out  2  tracked M Tnew.

Behaviour:
- Decode (combinational on instr_D). Tuse value 3 means "not used". Opcode/funct encodings are the standard MIPS-I ones the team decoder already uses.
  - cal_r (add/addu/sub/subu/and/or/xor/nor/slt/sltu/sllv/srlv/srav): Tuse rs=1, rt=1; dst=rd; Tnew=1.
  - sll/srl/sra: rs=3, rt=1; dst=rd; Tnew=1.
  - cal_i (addi/addiu/andi/ori/xori/lui/slti/sltiu): rs=1, rt=3; dst=rt; Tnew=1.
  - load (lw/lh/lhu/lb/lbu): rs=1; dst=rt; Tnew=2.
  - store (sw/sh/sb): rs=1, rt=2; no dst.
  - beq/bne: rs=0, rt=0. blez/bgtz/bltz/bgez: rs=0, rt=3.
  - jr: rs=0. jalr: rs=0; dst=rd; Tnew=0.
  - jal: dst=31; Tnew=0.
  - mult/multu/div/divu: rs=1, rt=1; no dst.
  - mthi/mtlo: rs=1. mfhi/mflo: dst=rd; Tnew=1.
  - Unrecognised encodings and nop: all Tuse=3, no dst.
  - "No dst" is encoded as dst=0. dst=0 is never a hazard source.
- Data stall conditions (combinational):
  - rs_D!=0 and rs_D==dst_E and tnew_E>Tuse_rs.
  - rs_D!=0 and rs_D==dst_M and tnew_M>Tuse_rs.
  - The same two checks for rt.
- md stall (combinational): D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo, and either md_busy=1 or the tracked E holds mult/div (start_E).
- stall = data stall OR md stall.
- Register update each edge:
  - If stall: E shadow <= bubble (dst 0, tnew 0, start_E 0). Otherwise E shadow <= decode of instr_D.
  - Always: dst_M <= dst_E; tnew_M <= tnew_E minus 1, saturating at 0. W is not tracked, since Tnew is 0 there.
- Busy counter:
  - If start_E: cnt <= MULT_LAT (mult/multu) or DIV_LAT (div/divu).
  - Else if cnt!=0: cnt <= cnt-1.
  - md_busy = (cnt!=0).
  - A new mult/div cannot reach E while busy, because D is stalled.
- Reset: cnt=0; E and M shadows cleared (dst 0, tnew 0, start_E 0).
  - Outputs after reset: stall=0 (for a non-hazard instr_D), md_busy=0, dst_E=0, tnew_E=0, dst_M=0, tnew_M=0.
  - Reset asserted mid-busy aborts the count at the next edge.
- A stall never lasts more than 2 cycles for data hazards.
- md stall lasts until cnt reaches 0; the instruction is released in the cycle md_busy is 0.

Test Plan:
- lw $8,0($9) then addu $10,$8,$11 in D → stall=1 for 1 cycle (tnew_E=2>1). Next cycle dst_M=8, tnew_M=1, stall=0.
- lw $8 then beq $8,$0 in D → stall 2 cycles (E: 2>0; then M: 1>0). Released on 3rd cycle.
- ori $4 then sw $4,0($5) → no stall (rt Tuse=2 ≥ tnew_E=1). addu $0 followed by dependent use of $0 → no stall.
- mult $1,$2 leaves D, then mflo $3 in D → stall for the E cycle plus MULT_LAT=5 busy cycles (6 total). md_busy falls after exactly 5 cycles.
- div with DIV_LAT=10, reset asserted at busy cycle 4 → next edge cnt=0, md_busy=0, stall=0 for the pending mfhi.
- jal in E then jr $31 in D → no stall (Tnew 0). jalr $7,$2 in D with lw $2 in E → stall 2 cycles.
